// File: rtl/npu_act_pkg.sv
// ---------------------------------------------------------------------------
// npu_act_pkg
// Shared types, default widths and helpers for the activation-memory port
// controller (npu_act_mem_port_arbiter) and its round-robin arbiter.
//
// Contents:
//   rd_src_e     - read source selected for an in-flight read
//   ADDR_W, DATA_W, RGB_W, FRAC_SHIFT - default widths
//   ZC_W         - internal width used by zero_centre()
//   zero_centre  - (rgb << shift) - (mean << shift) at ZC_W bits
// ---------------------------------------------------------------------------
package npu_act_pkg;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 16;
    localparam int RGB_W      = 8;
    localparam int FRAC_SHIFT = 5;

    // Wide enough for any legal pixel/shift combination; callers truncate
    // the result to their own DATA_W.
    localparam int ZC_W = 32;

    typedef enum logic [1:0] {
        SRC_PAD = 2'd0,
        SRC_RGB = 2'd1,
        SRC_ACT = 2'd2
    } rd_src_e;

    // Zero-centred pixel: both operands are zero-extended by the caller and
    // scaled to the fixed-point format before the subtraction, so the result
    // is exact as long as DATA_W >= RGB_W + FRAC_SHIFT + 1.
    function automatic logic signed [ZC_W-1:0] zero_centre(
        input logic [ZC_W-1:0] rgb,
        input logic [ZC_W-1:0] mean,
        input int              frac_shift
    );
        logic [ZC_W-1:0] diff;
        diff = (rgb << frac_shift) - (mean << frac_shift);
        return signed'(diff);
    endfunction

endpackage : npu_act_pkg

// File: rtl/npu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// npu_rr_arbiter
// Work-conserving round-robin arbiter. The grant is the first set req bit at
// or after rr_ptr, searching circularly; on an accepted grant rr_ptr moves to
// the lane after the winner, otherwise it holds.
//
// Parameters:
//   N        - number of requesters (1..64)
// Ports:
//   clk      in   clock
//   resetn   in   asynchronous active-low reset (rr_ptr -> 0)
//   req      in   [N]      level requests
//   advance  in   1        grant enable; when low no grant is issued and
//                          rr_ptr holds
//   gnt      out  [N]      one-hot grant (combinational)
//   gnt_idx  out  [IDX_W]  index of the granted lane (valid when |gnt)
// ---------------------------------------------------------------------------
module npu_rr_arbiter
    import npu_act_pkg::*;
#(
    parameter  int N     = 32,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] rr_ptr_reg;
    logic [IDX_W-1:0] rr_ptr_next;
    logic             found;
    logic [IDX_W-1:0] idx;
    int               cand;

    // Circular priority search starting at rr_ptr. The first hit wins; later
    // hits are masked by 'found'.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (advance && found) begin
            gnt[idx] = 1'b1;
        end
    end

    assign gnt_idx = idx;

    // Wrap explicitly so non-power-of-two N works; with N=1 this always
    // yields 0, so the pointer is a constant.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (advance && found) begin
            if (int'(idx) >= N - 1) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule : npu_rr_arbiter

// File: rtl/npu_act_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// npu_act_mem_port_arbiter
// Activation-memory port controller between the NPU compute lanes and the
// single-port activation SRAM.
//   Write side: round-robin arbitration of NUM_REQ held write requests, one
//     write per cycle, registered SRAM write port one cycle after the ack.
//   Read side: 3-stage pipeline returning zero padding, zero-centred RGB
//     pixels or raw activations, one result per read strobe.
//
// Optional feature macro: NPU_ACT_TEST_IMG_EN
//   When defined, test_mode_i/test_rdata_i exist and an RGB read with
//   test_mode_i=1 returns test_rdata_i instead of the zero-centred pixel.
//
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   wr_req    [NUM_REQ]            level write requests, held until ack
//   wr_addr   [NUM_REQ*ADDR_W]     packed per-lane addresses
//   wr_data   [NUM_REQ*DATA_W]     packed per-lane data
//   wr_ack_p  [NUM_REQ]            one-hot grant pulse (combinational)
//   mem_wr_en/addr/data            registered SRAM write port
//   rd_rgb, rd_act, rd_bypass      read strobes (bypass > rgb > act)
//   rd_ch     [2]                  channel of an RGB read
//   rgb_rdata [RGB_W]              image data, one cycle after rd_rgb
//   act_rdata [DATA_W]             SRAM data, one cycle after rd_act
//   mean_i    [NUM_CH*RGB_W]       per-channel means (quasi-static)
//   test_mode_i, test_rdata_i      only with NPU_ACT_TEST_IMG_EN
//   rd_data_o [DATA_W], rd_valid_o registered read result
// ---------------------------------------------------------------------------
module npu_act_mem_port_arbiter #(
    parameter int NUM_REQ    = 32,
    parameter int ADDR_W     = npu_act_pkg::ADDR_W,
    parameter int DATA_W     = npu_act_pkg::DATA_W,
    parameter int RGB_W      = npu_act_pkg::RGB_W,
    parameter int FRAC_SHIFT = npu_act_pkg::FRAC_SHIFT,
    parameter int NUM_CH     = 3
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_REQ-1:0]          wr_req,
    input  logic [NUM_REQ*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   wr_data,
    output logic [NUM_REQ-1:0]          wr_ack_p,
    output logic                        mem_wr_en,
    output logic [ADDR_W-1:0]           mem_wr_addr,
    output logic [DATA_W-1:0]           mem_wr_data,
    input  logic                        rd_rgb,
    input  logic                        rd_act,
    input  logic                        rd_bypass,
    input  logic [1:0]                  rd_ch,
    input  logic [RGB_W-1:0]            rgb_rdata,
    input  logic [DATA_W-1:0]           act_rdata,
    input  logic [NUM_CH*RGB_W-1:0]     mean_i,
`ifdef NPU_ACT_TEST_IMG_EN
    input  logic                        test_mode_i,
    input  logic [DATA_W-1:0]           test_rdata_i,
`endif
    output logic [DATA_W-1:0]           rd_data_o,
    output logic                        rd_valid_o
);

    import npu_act_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (NUM_REQ < 1 || NUM_REQ > 64) begin : g_bad_num_req
        $error("NUM_REQ must be in 1..64");
    end
    if (DATA_W < RGB_W + FRAC_SHIFT + 1) begin : g_bad_data_w
        $error("DATA_W too narrow for zero-centred pixels");
    end
    if (DATA_W > ZC_W || RGB_W + FRAC_SHIFT + 1 > ZC_W) begin : g_bad_zc_w
        $error("widths exceed zero_centre() internal width");
    end
    if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_num_ch
        $error("NUM_CH must be in 1..4 (rd_ch is 2 bits)");
    end

    // ------------------------------------------------------------------
    // Write arbitration
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;

    logic [ADDR_W-1:0]  lane_addr [NUM_REQ];
    logic [DATA_W-1:0]  lane_data [NUM_REQ];

    logic               mem_wr_en_reg;
    logic [ADDR_W-1:0]  mem_wr_addr_reg;
    logic [DATA_W-1:0]  mem_wr_data_reg;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane_addr[gi] = wr_addr[gi*ADDR_W +: ADDR_W];
        assign lane_data[gi] = wr_data[gi*DATA_W +: DATA_W];
    end

    // Tying advance to resetn suppresses grants while reset is asserted, so
    // no requester sees an ack that would be discarded.
    npu_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .resetn  (resetn),
        .req     (wr_req),
        .advance (resetn),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign gnt_any  = |gnt;
    assign wr_ack_p = gnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_wr_en_reg   <= 1'b0;
            mem_wr_addr_reg <= '0;
            mem_wr_data_reg <= '0;
        end else begin
            mem_wr_en_reg <= gnt_any;
            if (gnt_any) begin
                mem_wr_addr_reg <= lane_addr[gnt_idx];
                mem_wr_data_reg <= lane_data[gnt_idx];
            end
        end
    end

    assign mem_wr_en   = mem_wr_en_reg;
    assign mem_wr_addr = mem_wr_addr_reg;
    assign mem_wr_data = mem_wr_data_reg;

    // ------------------------------------------------------------------
    // Read pipeline
    //   stage 0: strobes decoded to a source, channel mean selected
    //   stage 1: returning data muxed / zero-centred
    //   stage 2: registered result
    // ------------------------------------------------------------------
    logic [RGB_W-1:0]   ch_mean [NUM_CH];
    logic [RGB_W-1:0]   mean_next;
    rd_src_e            src_next;
    logic               s1_valid_next;

    logic               s1_valid_reg;
    rd_src_e            s1_src_reg;
    logic [RGB_W-1:0]   s1_mean_reg;

    logic [DATA_W-1:0]  pix_centred;
    logic [DATA_W-1:0]  rgb_result;
    logic [DATA_W-1:0]  rd_data_next;

    logic [DATA_W-1:0]  rd_data_reg;
    logic               rd_valid_reg;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mean
        assign ch_mean[gi] = mean_i[gi*RGB_W +: RGB_W];
    end

    // Channels without a programmed mean read as mean 0.
    always_comb begin
        mean_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == 2'(c)) begin
                mean_next = ch_mean[c];
            end
        end
    end

    always_comb begin
        s1_valid_next = rd_bypass | rd_rgb | rd_act;
        if (rd_bypass) begin
            src_next = SRC_PAD;
        end else if (rd_rgb) begin
            src_next = SRC_RGB;
        end else begin
            src_next = SRC_ACT;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_reg <= 1'b0;
            s1_src_reg   <= SRC_PAD;
            s1_mean_reg  <= '0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            s1_src_reg   <= src_next;
            s1_mean_reg  <= mean_next;
        end
    end

    assign pix_centred = DATA_W'(zero_centre(ZC_W'(rgb_rdata), ZC_W'(s1_mean_reg), FRAC_SHIFT));

`ifdef NPU_ACT_TEST_IMG_EN
    assign rgb_result = test_mode_i ? test_rdata_i : pix_centred;
`else
    assign rgb_result = pix_centred;
`endif

    always_comb begin
        rd_data_next = '0;
        case (s1_src_reg)
            SRC_PAD: rd_data_next = '0;
            SRC_RGB: rd_data_next = rgb_result;
            SRC_ACT: rd_data_next = act_rdata;
            default: rd_data_next = '0;
        endcase
    end

    // The data register only loads on a valid read so idle cycles leave the
    // last result in place.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                rd_data_reg <= rd_data_next;
            end
        end
    end

    assign rd_valid_o = rd_valid_reg;
    assign rd_data_o  = rd_data_reg;

endmodule : npu_act_mem_port_arbiter

// File: tb/tb_npu_act_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_npu_act_mem_port_arbiter
// Self-checking bench for npu_act_mem_port_arbiter (default parameters).
// Inputs change 1 ns after the rising edge; outputs are checked on the
// falling edge. Expected values come from a behavioural model of the
// round-robin rule and the read-path arithmetic.
// ---------------------------------------------------------------------------
module tb_npu_act_mem_port_arbiter;

    localparam int NUM_REQ    = 32;
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 16;
    localparam int RGB_W      = 8;
    localparam int FRAC_SHIFT = 5;
    localparam int NUM_CH     = 3;

    logic                      clk = 1'b0;
    logic                      resetn;
    logic [NUM_REQ-1:0]        wr_req;
    logic [NUM_REQ*ADDR_W-1:0] wr_addr;
    logic [NUM_REQ*DATA_W-1:0] wr_data;
    logic [NUM_REQ-1:0]        wr_ack_p;
    logic                      mem_wr_en;
    logic [ADDR_W-1:0]         mem_wr_addr;
    logic [DATA_W-1:0]         mem_wr_data;
    logic                      rd_rgb, rd_act, rd_bypass;
    logic [1:0]                rd_ch;
    logic [RGB_W-1:0]          rgb_rdata;
    logic [DATA_W-1:0]         act_rdata;
    logic [NUM_CH*RGB_W-1:0]   mean_i;
    logic [DATA_W-1:0]         rd_data_o;
    logic                      rd_valid_o;
`ifdef NPU_ACT_TEST_IMG_EN
    logic                      test_mode_i = 1'b0;
    logic [DATA_W-1:0]         test_rdata_i = '0;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    npu_act_mem_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .RGB_W(RGB_W), .FRAC_SHIFT(FRAC_SHIFT), .NUM_CH(NUM_CH)
    ) dut (
        .clk(clk), .resetn(resetn),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack_p(wr_ack_p),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .rd_rgb(rd_rgb), .rd_act(rd_act), .rd_bypass(rd_bypass), .rd_ch(rd_ch),
        .rgb_rdata(rgb_rdata), .act_rdata(act_rdata), .mean_i(mean_i),
`ifdef NPU_ACT_TEST_IMG_EN
        .test_mode_i(test_mode_i), .test_rdata_i(test_rdata_i),
`endif
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o)
    );

    // Behavioural round-robin: first requesting lane at or after ptr.
    function automatic int model_grant(input logic [NUM_REQ-1:0] req, input int ptr);
        int l;
        for (int k = 0; k < NUM_REQ; k++) begin
            l = (ptr + k) % NUM_REQ;
            if (req[l]) return l;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int g);
        logic [NUM_REQ-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] model_centre(input int pix, input int mean);
        int          e;
        logic [31:0] t;
        e = pix * (1 << FRAC_SHIFT) - mean * (1 << FRAC_SHIFT);
        t = e;
        return t[DATA_W-1:0];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        wr_req = '0;
        rd_rgb = 1'b0; rd_act = 1'b0; rd_bypass = 1'b0;
        next_cycle();
        next_cycle();
        resetn = 1'b1;
    endtask

    task automatic set_lane(input int l);
        wr_addr[l*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        wr_data[l*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        resetn = 1'b0;
        wr_req = '1;
        rd_rgb = 1'b1; rd_act = 1'b1; rd_bypass = 1'b0; rd_ch = 2'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors += 6;
            if (wr_ack_p !== '0) begin miscompares++; $display("FAIL reset_ack got=%h want=0", wr_ack_p); end
            if (mem_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got=%b want=0", mem_wr_en); end
            if (mem_wr_addr !== '0) begin miscompares++; $display("FAIL reset_wr_addr got=%h want=0", mem_wr_addr); end
            if (mem_wr_data !== '0) begin miscompares++; $display("FAIL reset_wr_data got=%h want=0", mem_wr_data); end
            if (rd_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid_o); end
            if (rd_data_o !== '0) begin miscompares++; $display("FAIL reset_rd_data got=%h want=0", rd_data_o); end
            next_cycle();
        end
        $display("reset: outputs held at zero for 3 cycles");
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_lane();
        logic [ADDR_W-1:0] a5, a6;
        logic [DATA_W-1:0] d5;
        do_reset();
        set_lane(5); set_lane(6); set_lane(4);
        a5 = wr_addr[5*ADDR_W +: ADDR_W];
        d5 = wr_data[5*DATA_W +: DATA_W];
        a6 = wr_addr[6*ADDR_W +: ADDR_W];
        wr_req = onehot(5);
        @(negedge clk);
        vectors++;
        if (wr_ack_p !== onehot(5)) begin miscompares++; $display("FAIL single_ack got=%h want=%h", wr_ack_p, onehot(5)); end
        next_cycle();
        wr_req = '0;
        @(negedge clk);
        vectors += 4;
        if (wr_ack_p !== '0) begin miscompares++; $display("FAIL single_ack_drop got=%h want=0", wr_ack_p); end
        if (mem_wr_en !== 1'b1) begin miscompares++; $display("FAIL single_wr_en got=%b want=1", mem_wr_en); end
        if (mem_wr_addr !== a5) begin miscompares++; $display("FAIL single_wr_addr got=%h want=%h", mem_wr_addr, a5); end
        if (mem_wr_data !== d5) begin miscompares++; $display("FAIL single_wr_data got=%h want=%h", mem_wr_data, d5); end
        next_cycle();
        // Lanes 4 and 6 together: pointer at 6 must favour lane 6.
        wr_req = onehot(4) | onehot(6);
        @(negedge clk);
        vectors += 2;
        if (wr_ack_p !== onehot(6)) begin miscompares++; $display("FAIL ptr6_ack got=%h want=%h", wr_ack_p, onehot(6)); end
        if (mem_wr_en !== 1'b0) begin miscompares++; $display("FAIL idle_wr_en got=%b want=0", mem_wr_en); end
        next_cycle();
        wr_req = onehot(4);
        @(negedge clk);
        vectors += 2;
        if (wr_ack_p !== onehot(4)) begin miscompares++; $display("FAIL ptr7_ack got=%h want=%h", wr_ack_p, onehot(4)); end
        if (mem_wr_addr !== a6) begin miscompares++; $display("FAIL lane6_addr got=%h want=%h", mem_wr_addr, a6); end
        next_cycle();
        wr_req = '0;
        $display("single_lane: lane 5 acked, then 6 before 4");
    endtask

    // ------------------------------------------------------------------
    task automatic test_held_lanes();
        int                order [3];
        int                g, prev;
        logic [DATA_W-1:0] prev_d;
        order[0] = 0; order[1] = 3; order[2] = 31;
        do_reset();
        set_lane(0); set_lane(3); set_lane(31);
        wr_req = onehot(0) | onehot(3) | onehot(31);
        prev = -1; prev_d = '0;
        for (int i = 0; i < 12; i++) begin
            g = order[i % 3];
            @(negedge clk);
            vectors++;
            if (wr_ack_p !== onehot(g)) begin miscompares++; $display("FAIL held_ack[%0d] got=%h want=%h", i, wr_ack_p, onehot(g)); end
            if (prev >= 0) begin
                vectors += 2;
                if (mem_wr_en !== 1'b1) begin miscompares++; $display("FAIL held_wr_en[%0d] got=%b want=1", i, mem_wr_en); end
                if (mem_wr_data !== prev_d) begin miscompares++; $display("FAIL held_wr_data[%0d] got=%h want=%h", i, mem_wr_data, prev_d); end
            end
            prev   = g;
            prev_d = wr_data[g*DATA_W +: DATA_W];
            next_cycle();
            set_lane(g);   // same lane keeps requesting with its next word
        end
        wr_req = '0;
        $display("held_lanes: 12 grants in order 0,3,31 without idle cycles");
    endtask

    // ------------------------------------------------------------------
    task automatic test_all_lanes();
        logic [ADDR_W-1:0] pa;
        logic [DATA_W-1:0] pd;
        do_reset();
        for (int l = 0; l < NUM_REQ; l++) set_lane(l);
        wr_req = '1;
        pa = '0; pd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            @(negedge clk);
            vectors++;
            if (wr_ack_p !== onehot(i)) begin miscompares++; $display("FAIL all_ack[%0d] got=%h want=%h", i, wr_ack_p, onehot(i)); end
            if (i > 0) begin
                vectors += 3;
                if (mem_wr_en !== 1'b1) begin miscompares++; $display("FAIL all_wr_en[%0d] got=%b want=1", i, mem_wr_en); end
                if (mem_wr_addr !== pa) begin miscompares++; $display("FAIL all_wr_addr[%0d] got=%h want=%h", i, mem_wr_addr, pa); end
                if (mem_wr_data !== pd) begin miscompares++; $display("FAIL all_wr_data[%0d] got=%h want=%h", i, mem_wr_data, pd); end
            end
            pa = wr_addr[i*ADDR_W +: ADDR_W];
            pd = wr_data[i*DATA_W +: DATA_W];
            next_cycle();
            wr_req[i] = 1'b0;
        end
        @(negedge clk);
        vectors += 2;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== pa) begin miscompares++; $display("FAIL all_last_write got=%b/%h want=1/%h", mem_wr_en, mem_wr_addr, pa); end
        if (wr_ack_p !== '0) begin miscompares++; $display("FAIL all_idle_ack got=%h want=0", wr_ack_p); end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (mem_wr_en !== 1'b0) begin miscompares++; $display("FAIL all_done_wr_en got=%b want=0", mem_wr_en); end
        next_cycle();
        $display("all_lanes: 32 writes in lane order, then idle");
    endtask

    // ------------------------------------------------------------------
    task automatic test_random_writes();
        int                ptr, g;
        int                waits [NUM_REQ];
        logic              pv;
        logic [ADDR_W-1:0] pa;
        logic [DATA_W-1:0] pd;
        do_reset();
        ptr = 0; pv = 1'b0; pa = '0; pd = '0;
        for (int l = 0; l < NUM_REQ; l++) waits[l] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < NUM_REQ; l++) begin
                if (!wr_req[l] && ($urandom % 4 == 0)) begin
                    wr_req[l] = 1'b1;
                    set_lane(l);
                end
            end
            @(negedge clk);
            g = model_grant(wr_req, ptr);
            vectors += 2;
            if (wr_ack_p !== onehot(g)) begin miscompares++; $display("FAIL rnd_ack[%0d] got=%h want=%h", c, wr_ack_p, onehot(g)); end
            if (mem_wr_en !== pv) begin miscompares++; $display("FAIL rnd_wr_en[%0d] got=%b want=%b", c, mem_wr_en, pv); end
            if (pv) begin
                vectors++;
                if (mem_wr_addr !== pa || mem_wr_data !== pd) begin
                    miscompares++;
                    $display("FAIL rnd_write[%0d] got=%h/%h want=%h/%h", c, mem_wr_addr, mem_wr_data, pa, pd);
                end
            end
            pv = (g >= 0);
            if (g >= 0) begin
                vectors++;
                if (waits[g] >= NUM_REQ) begin miscompares++; $display("FAIL rnd_fair lane=%0d waited=%0d want<%0d", g, waits[g], NUM_REQ); end
                pa = wr_addr[g*ADDR_W +: ADDR_W];
                pd = wr_data[g*DATA_W +: DATA_W];
                ptr = (g + 1) % NUM_REQ;
            end
            for (int l = 0; l < NUM_REQ; l++) begin
                if (l == g) waits[l] = 0;
                else if (wr_req[l]) waits[l]++;
            end
            next_cycle();
            if (g >= 0) begin
                if ($urandom % 2 == 0) wr_req[g] = 1'b0;
                else set_lane(g);
            end
        end
        wr_req = '0;
        $display("random_writes: 400 cycles of random held requests");
    endtask

    // ------------------------------------------------------------------
    task automatic test_rgb_read();
        do_reset();
        mean_i = {8'h33, 8'h20, 8'h11};
        rd_rgb = 1'b1; rd_ch = 2'd1;
        @(negedge clk);
        vectors++;
        if (rd_valid_o !== 1'b0) begin miscompares++; $display("FAIL rgb_c0_valid got=%b want=0", rd_valid_o); end
        next_cycle();
        rd_rgb = 1'b0; rgb_rdata = 8'h80;
        @(negedge clk);
        vectors++;
        if (rd_valid_o !== 1'b0) begin miscompares++; $display("FAIL rgb_c1_valid got=%b want=0", rd_valid_o); end
        next_cycle();
        rgb_rdata = 8'h00;
        @(negedge clk);
        vectors += 2;
        if (rd_valid_o !== 1'b1) begin miscompares++; $display("FAIL rgb_valid got=%b want=1", rd_valid_o); end
        if (rd_data_o !== 16'h0C00) begin miscompares++; $display("FAIL rgb_data got=%h want=0c00", rd_data_o); end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (rd_valid_o !== 1'b0) begin miscompares++; $display("FAIL rgb_after_valid got=%b want=0", rd_valid_o); end
        next_cycle();
        $display("rgb_read: 0x80 - mean 0x20 -> %h", rd_data_o);
    endtask

    // ------------------------------------------------------------------
    task automatic test_bypass();
        rd_bypass = 1'b1; rd_act = 1'b1;
        next_cycle();
        rd_bypass = 1'b0; rd_act = 1'b0; act_rdata = 16'h1234;
        next_cycle();
        act_rdata = '0;
        @(negedge clk);
        vectors += 2;
        if (rd_valid_o !== 1'b1) begin miscompares++; $display("FAIL bypass_valid got=%b want=1", rd_valid_o); end
        if (rd_data_o !== 16'h0000) begin miscompares++; $display("FAIL bypass_data got=%h want=0000", rd_data_o); end
        next_cycle();
        $display("bypass: pad beats act -> %h", rd_data_o);
    endtask

    // ------------------------------------------------------------------
    task automatic test_random_reads();
        localparam int L = 200;
        logic [2:0]        stb  [L+2];
        logic [1:0]        chs  [L+2];
        logic [RGB_W-1:0]  rgbd [L+2];
        logic [DATA_W-1:0] actd [L+2];
        int                means [4];
        int                u;
        logic              ev;
        logic [DATA_W-1:0] ed;
        do_reset();
        for (int c = 0; c < 4; c++) means[c] = (c < NUM_CH) ? int'($urandom_range(0, 255)) : 0;
        for (int c = 0; c < NUM_CH; c++) mean_i[c*RGB_W +: RGB_W] = RGB_W'(means[c]);
        for (int t = 0; t < L + 2; t++) begin
            stb[t]  = (t >= L || $urandom % 4 == 0) ? 3'b000 : 3'($urandom);
            chs[t]  = 2'($urandom);
            rgbd[t] = RGB_W'($urandom);
            actd[t] = DATA_W'($urandom);
        end
        for (int t = 0; t < L + 2; t++) begin
            {rd_bypass, rd_rgb, rd_act} = stb[t];
            rd_ch = chs[t]; rgb_rdata = rgbd[t]; act_rdata = actd[t];
            @(negedge clk);
            if (t >= 2) begin
                u  = t - 2;
                ev = |stb[u];
                if (stb[u][2])      ed = '0;
                else if (stb[u][1]) ed = model_centre(int'(rgbd[u+1]), means[chs[u]]);
                else                ed = actd[u+1];
                vectors++;
                if (rd_valid_o !== ev) begin miscompares++; $display("FAIL rnd_rd_valid[%0d] got=%b want=%b", u, rd_valid_o, ev); end
                if (ev) begin
                    vectors++;
                    if (rd_data_o !== ed) begin miscompares++; $display("FAIL rnd_rd_data[%0d] src=%b ch=%0d got=%h want=%h", u, stb[u], chs[u], rd_data_o, ed); end
                end
            end
            next_cycle();
        end
        rd_bypass = 1'b0; rd_rgb = 1'b0; rd_act = 1'b0;
        $display("random_reads: %0d back-to-back read slots", L);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        logic [ADDR_W-1:0] a0;
        do_reset();
        set_lane(3); set_lane(0); set_lane(8);
        a0 = wr_addr[0 +: ADDR_W];
        wr_req = onehot(3);
        rd_act = 1'b1; act_rdata = 16'hBEEF;
        @(negedge clk);
        vectors++;
        if (wr_ack_p !== onehot(3)) begin miscompares++; $display("FAIL mid_ack3 got=%h want=%h", wr_ack_p, onehot(3)); end
        next_cycle();
        // Pointer now 4; a write and a read are in flight.
        wr_req = onehot(0) | onehot(8);
        rd_act = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        vectors += 6;
        if (wr_ack_p !== '0) begin miscompares++; $display("FAIL mid_rst_ack got=%h want=0", wr_ack_p); end
        if (mem_wr_en !== 1'b0) begin miscompares++; $display("FAIL mid_rst_wr_en got=%b want=0", mem_wr_en); end
        if (mem_wr_addr !== '0) begin miscompares++; $display("FAIL mid_rst_wr_addr got=%h want=0", mem_wr_addr); end
        if (mem_wr_data !== '0) begin miscompares++; $display("FAIL mid_rst_wr_data got=%h want=0", mem_wr_data); end
        if (rd_valid_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rd_valid got=%b want=0", rd_valid_o); end
        if (rd_data_o !== '0) begin miscompares++; $display("FAIL mid_rst_rd_data got=%h want=0", rd_data_o); end
        next_cycle();
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        vectors += 2;
        if (wr_ack_p !== onehot(0)) begin miscompares++; $display("FAIL mid_after_ack0 got=%h want=%h", wr_ack_p, onehot(0)); end
        if (rd_valid_o !== 1'b0) begin miscompares++; $display("FAIL mid_after_rd_valid got=%b want=0", rd_valid_o); end
        next_cycle();
        wr_req = onehot(8);
        @(negedge clk);
        vectors += 3;
        if (wr_ack_p !== onehot(8)) begin miscompares++; $display("FAIL mid_after_ack8 got=%h want=%h", wr_ack_p, onehot(8)); end
        if (mem_wr_en !== 1'b1) begin miscompares++; $display("FAIL mid_after_wr_en got=%b want=1", mem_wr_en); end
        if (mem_wr_addr !== a0) begin miscompares++; $display("FAIL mid_after_wr_addr got=%h want=%h", mem_wr_addr, a0); end
        next_cycle();
        wr_req = '0;
        $display("reset_mid: pointer restarted at 0, lanes 0 then 8 served");
    endtask

    initial begin
        resetn    = 1'b0;
        wr_req    = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_rgb    = 1'b0;
        rd_act    = 1'b0;
        rd_bypass = 1'b0;
        rd_ch     = 2'd0;
        rgb_rdata = '0;
        act_rdata = '0;
        mean_i    = '0;
        #1;
        test_reset();
        test_single_lane();
        test_held_lanes();
        test_all_lanes();
        test_random_writes();
        test_rgb_read();
        test_bypass();
        test_random_reads();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_npu_act_mem_port_arbiter

// File: doc/npu_act_mem_port_arbiter.md
# npu_act_mem_port_arbiter

Parametrised activation-memory port controller between the NPU compute lanes and the single-port activation SRAM. It arbitrates up to NUM_REQ held write requests with a work-conserving round-robin arbiter that grants only requesting lanes and never spends idle slots. It also returns one read stream per read strobe, muxing zero-padding, zero-centred RGB pixels and raw activations.

## Interface
Parameters:
- NUM_REQ, 32, number of write requesters (1..64)
- ADDR_W, 12, activation memory address width
- DATA_W, 16, activation word width (signed)
- RGB_W, 8, raw pixel width
- FRAC_SHIFT, 5, fixed-point left shift applied to pixels and means
- NUM_CH, 3, colour channels with programmable mean

Ports:
- clk, in, 1, single clock; every register samples on its rising edge
- resetn, in, 1, asynchronous active-low reset
- wr_req, in, NUM_REQ, level write requests; each bit is held until its ack
- wr_addr, in, NUM_REQ*ADDR_W, packed per-lane address; lane i uses bits [i*ADDR_W +: ADDR_W]
- wr_data, in, NUM_REQ*DATA_W, packed per-lane data
- wr_ack_p, out, NUM_REQ, one-hot single-cycle grant pulse
- mem_wr_en, out, 1, registered SRAM write enable
- mem_wr_addr, out, ADDR_W, registered SRAM write address
- mem_wr_data, out, DATA_W, registered SRAM write data
- rd_rgb, in, 1, current read targets the RGB image buffer
- rd_act, in, 1, current read targets activation memory
- rd_bypass, in, 1, current read is a pad position; return zero
- rd_ch, in, 2, channel of the current RGB read (0..NUM_CH-1; other values use mean 0)
- rgb_rdata, in, RGB_W, image buffer data, arriving one cycle after rd_rgb
- act_rdata, in, DATA_W, activation SRAM data, arriving one cycle after rd_act
- mean_i, in, NUM_CH*RGB_W, packed per-channel means; treated as quasi-static
- rd_data_o, out, DATA_W, returned read word
- rd_valid_o, out, 1, rd_data_o valid this cycle
- test_mode_i, in, 1, present only with NPU_ACT_TEST_IMG_EN
- test_rdata_i, in, DATA_W, present only with NPU_ACT_TEST_IMG_EN

## Operation
- Arbiter state is the round-robin pointer rr_ptr [clog2(NUM_REQ)].
- Grant g is the first set wr_req bit at or after rr_ptr, searching circularly.
- wr_ack_p[g] is combinational in the same cycle as the grant.
- On a grant, rr_ptr <= (g+1) mod NUM_REQ.
- With no requests, rr_ptr holds.
- The cycle after a grant: mem_wr_en=1, mem_wr_addr=wr_addr[g], mem_wr_data=wr_data[g]. Address and data are sampled in the ack cycle.
- A lane sampling its ack must drop wr_req or present the next request on the following cycle. A bit still asserted after its ack is a new request.
- Fairness: a held request is granted within NUM_REQ cycles. Throughput is one write per cycle under any load.
- NUM_REQ=1: rr_ptr is a constant 0 and a held request is granted every cycle.
- Read path, source priority: rd_bypass > rd_rgb > rd_act.
- A cycle with no strobe produces no rd_valid_o.
- Zero-centred RGB = (zero-extended rgb_rdata << FRAC_SHIFT) - (zero-extended mean[ch] << FRAC_SHIFT), taken as signed DATA_W.
- DATA_W < RGB_W+FRAC_SHIFT+1 is an elaboration error. No saturation is needed.

## Timing
- Reset values: wr_ack_p=0 (no requests are evaluated in reset), mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, rd_data_o=0, rd_valid_o=0, rr_ptr=0.
- Write latency: request to ack is 0 cycles when uncontested; ack to mem_wr_en is 1 cycle.
- Read pipeline:
  - cycle 0: strobes and rd_ch registered, mean[rd_ch] selected into a register.
  - cycle 1: SRAM or image data arrives and is muxed and computed.
  - cycle 2: rd_data_o and rd_valid_o are registered outputs.
- Back-to-back reads give one result per cycle.
- Reset mid-operation: in-flight writes and reads are discarded and rr_ptr returns to 0. Requesters keep wr_req asserted and are re-served after reset.
- A write grant and a read in the same cycle are independent; the SRAM wrapper resolves port use.

## Configuration
- NPU_ACT_TEST_IMG_EN defined: test_mode_i and test_rdata_i ports exist. With test_mode_i=1, an RGB read returns test_rdata_i (sampled in cycle 1) instead of the zero-centred pixel.
- NPU_ACT_TEST_IMG_EN undefined: those ports are absent and RGB reads always return the zero-centred pixel.

## Structure
- Package npu_act_pkg holds:
  - enum rd_src_e (SRC_PAD, SRC_RGB, SRC_ACT)
  - default widths ADDR_W, DATA_W, RGB_W, FRAC_SHIFT
  - function zero_centre(rgb, mean)
- Sub-module npu_rr_arbiter (parameter N): inputs req and advance, outputs one-hot gnt and gnt_idx, owns rr_ptr.

## Test plan
- Only wr_req[5] set, rr_ptr=0 -> ack[5] the same cycle; next cycle mem_wr_en=1 with lane 5 addr/data; rr_ptr=6.
- wr_req[0], [3] and [31] held continuously (lanes drop and re-raise after ack) -> grant order 0, 3, 31, 0, 3, … with no idle cycles.
- All 32 lanes requesting, each dropping after its ack -> 32 consecutive writes in lane order 0..31; then mem_wr_en=0.
- rd_rgb with rgb_rdata=0x80, mean[1]=0x20, rd_ch=1 -> rd_data_o=0x0C00 two cycles later with rd_valid_o=1.
- rd_bypass and rd_act asserted together, act_rdata=0x1234 -> rd_data_o=0x0000.
- resetn pulsed low while wr_req=0x0000_0101 and rr_ptr=4 -> all outputs 0; after release, ack[0] then ack[8].
